stereo_fifo_arbiter: RTL and testbench

Shares one downstream processing stage (a single de-emphasis IIR or gain stage) between the left and right audio channel FIFOs of the FM radio pipeline. It pops words from the two channel FIFOs according to a burst-based round-robin schedule, forwards each word with a channel tag, and tracks the left/right pop imbalance. It sits between the per-channel FIFOs after demodulation and a single shared filter instance. Its output feeds that instance's input FIFO.

---
 rtl/stereo_fifo_arbiter.sv | 133 +++++++++++++
 tb/tb_stereo_fifo_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_fifo_arbiter.sv
// Burst round-robin arbiter sharing one downstream stage between the left and right channel FIFOs.
// Define STRICT_ALTERNATE_EN for a strict L/R burst alternation that never leaves a channel early.
module stereo_fifo_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 1,
    parameter int SKEW_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        left_dout,
    input  logic                         left_empty,
    output logic                         left_rd_en,
    input  logic [DATA_WIDTH-1:0]        right_dout,
    input  logic                         right_empty,
    output logic                         right_rd_en,
    output logic [DATA_WIDTH-1:0]        out_din,
    output logic                         out_chan,
    output logic                         out_wr_en,
    input  logic                         out_full,
    output logic signed [SKEW_WIDTH-1:0] skew
);

    // state   | meaning
    // IDLE    | no grant; re-evaluates both FIFOs every cycle
    // SERVE_L | left channel granted
    // SERVE_R | right channel granted
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_L = 2'd1,
        SERVE_R = 2'd2
    } state_e;

    localparam logic [7:0] BURST_LAST = 8'(BURST_LEN);
    localparam logic signed [SKEW_WIDTH-1:0] SKEW_MAX = {1'b0, {(SKEW_WIDTH-1){1'b1}}};
    localparam logic signed [SKEW_WIDTH-1:0] SKEW_MIN = {1'b1, {(SKEW_WIDTH-1){1'b0}}};
`ifdef STRICT_ALTERNATE_EN
    localparam state_e STATE_RST = SERVE_L;
`else
    localparam state_e STATE_RST = IDLE;
`endif

    state_e                         state_q, state_d;
    logic                           last_served_q, last_served_d;
    logic [7:0]                     burst_cnt_q, burst_cnt_d;
    logic signed [SKEW_WIDTH-1:0]   skew_q, skew_d;

    logic grant_l, grant_r, pop, burst_end;

    assign grant_l     = (state_q == SERVE_L);
    assign grant_r     = (state_q == SERVE_R);
    assign left_rd_en  = !reset && grant_l && !left_empty  && !out_full;
    assign right_rd_en = !reset && grant_r && !right_empty && !out_full;
    assign pop         = left_rd_en | right_rd_en;
    assign burst_end   = pop && ((burst_cnt_q + 8'd1) == BURST_LAST);

    assign out_wr_en = pop;
    assign out_din   = grant_r ? right_dout : left_dout;
    assign out_chan  = grant_r && !reset;
    assign skew      = skew_q;

`ifdef STRICT_ALTERNATE_EN
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        burst_cnt_d   = burst_cnt_q;
        if (state_q == IDLE) begin
            state_d = SERVE_L;
        end else if (burst_end) begin
            burst_cnt_d   = 8'd0;
            last_served_d = grant_r;
            state_d       = grant_r ? SERVE_L : SERVE_R;
        end else if (pop) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
        end
    end
`else
    // last = 1 means right was served last, so left is preferred
    function automatic state_e pick(input logic last, input logic l_empty, input logic r_empty);
        if (last) begin
            if (!l_empty)      pick = SERVE_L;
            else if (!r_empty) pick = SERVE_R;
            else               pick = IDLE;
        end else begin
            if (!r_empty)      pick = SERVE_R;
            else if (!l_empty) pick = SERVE_L;
            else               pick = IDLE;
        end
    endfunction

    logic gnt_empty;
    assign gnt_empty = grant_r ? right_empty : left_empty;

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        burst_cnt_d   = burst_cnt_q;
        if (state_q == IDLE) begin
            state_d = pick(last_served_q, left_empty, right_empty);
        end else if (!out_full) begin
            if (gnt_empty || burst_end) begin
                burst_cnt_d   = 8'd0;
                last_served_d = grant_r;
                state_d       = pick(grant_r, left_empty, right_empty);
            end else begin
                burst_cnt_d = burst_cnt_q + 8'd1;
            end
        end
    end
`endif

    always_comb begin
        skew_d = skew_q;
        if (left_rd_en && (skew_q != SKEW_MAX))
            skew_d = skew_q + 1'b1;
        else if (right_rd_en && (skew_q != SKEW_MIN))
            skew_d = skew_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= STATE_RST;
            last_served_q <= 1'b1;
            burst_cnt_q   <= 8'd0;
            skew_q        <= '0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            burst_cnt_q   <= burst_cnt_d;
            skew_q        <= skew_d;
        end
    end

endmodule

// File: tb/tb_stereo_fifo_arbiter.sv
// Bench for stereo_fifo_arbiter: two instances (BURST_LEN 1 and 3) fed by queue-modelled show-ahead FIFOs.
// Expected {chan,data} words are pushed to a scoreboard when the FIFOs are loaded.
module tb_stereo_fifo_arbiter;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [31:0] ldout0, rdout0, odin0, ldout1, rdout1, odin1;
    logic lempty0, rempty0, lrd0, rrd0, owr0, ochan0, ofull0;
    logic lempty1, rempty1, lrd1, rrd1, owr1, ochan1, ofull1;
    logic signed [15:0] skew0, skew1;

    stereo_fifo_arbiter #(.DATA_WIDTH(32), .BURST_LEN(1), .SKEW_WIDTH(16)) u_bl1 (
        .clock(clock), .reset(reset),
        .left_dout(ldout0), .left_empty(lempty0), .left_rd_en(lrd0),
        .right_dout(rdout0), .right_empty(rempty0), .right_rd_en(rrd0),
        .out_din(odin0), .out_chan(ochan0), .out_wr_en(owr0), .out_full(ofull0),
        .skew(skew0)
    );

    stereo_fifo_arbiter #(.DATA_WIDTH(32), .BURST_LEN(3), .SKEW_WIDTH(16)) u_bl3 (
        .clock(clock), .reset(reset),
        .left_dout(ldout1), .left_empty(lempty1), .left_rd_en(lrd1),
        .right_dout(rdout1), .right_empty(rempty1), .right_rd_en(rrd1),
        .out_din(odin1), .out_chan(ochan1), .out_wr_en(owr1), .out_full(ofull1),
        .skew(skew1)
    );

    logic [31:0] lq0[$], rq0[$], lq1[$], rq1[$];
    logic [32:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic refresh();
        lempty0 = (lq0.size() == 0);
        ldout0  = lempty0 ? 32'h0 : lq0[0];
        rempty0 = (rq0.size() == 0);
        rdout0  = rempty0 ? 32'h0 : rq0[0];
        lempty1 = (lq1.size() == 0);
        ldout1  = lempty1 ? 32'h0 : lq1[0];
        rempty1 = (rq1.size() == 0);
        rdout1  = rempty1 ? 32'h0 : rq1[0];
    endtask

    // Observe instance d mid-cycle, then apply the pops of both instances after the edge.
    task automatic step(input int d, output logic wr, output logic ch, output logic [31:0] dat,
                        output logic rd, output logic signed [15:0] sk);
        logic l0, r0, l1, r1;
        logic [31:0] tmp;
        @(negedge clock);
        if (d == 0) begin
            wr = owr0; ch = ochan0; dat = odin0; rd = lrd0 | rrd0; sk = skew0;
        end else begin
            wr = owr1; ch = ochan1; dat = odin1; rd = lrd1 | rrd1; sk = skew1;
        end
        l0 = lrd0; r0 = rrd0; l1 = lrd1; r1 = rrd1;
        @(posedge clock);
        #1;
        if (l0 && lq0.size() != 0) tmp = lq0.pop_front();
        if (r0 && rq0.size() != 0) tmp = rq0.pop_front();
        if (l1 && lq1.size() != 0) tmp = lq1.pop_front();
        if (r1 && rq1.size() != 0) tmp = rq1.pop_front();
        refresh();
    endtask

    task automatic test_reset();
        logic [3:0] v;
        logic signed [15:0] s;
        reset = 1'b1; ofull0 = 1'b0; ofull1 = 1'b0;
        refresh();
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            v = (d == 0) ? {lrd0, rrd0, owr0, ochan0} : {lrd1, rrd1, owr1, ochan1};
            s = (d == 0) ? skew0 : skew1;
            n_cmp++;
            if (v !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_strobes dut%0d: got %b want 0000", d, v);
            end
            n_cmp++;
            if (s !== 16'sd0) begin
                n_err++;
                $display("FAIL reset_skew dut%0d: got %0d want 0", d, s);
            end
        end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_alternate();
        logic wr, ch, rd;
        logic [31:0] dat;
        logic signed [15:0] sk;
        logic [32:0] e;
        int nwr = 0, first = -1, last = -1;
        for (int i = 0; i < 4; i++) begin
            lq0.push_back(32'h10 + i);
            rq0.push_back(32'h20 + i);
            exp_q.push_back({1'b0, 32'h10 + i});
            exp_q.push_back({1'b1, 32'h20 + i});
        end
        refresh();
        for (int c = 0; c < 20; c++) begin
            step(0, wr, ch, dat, rd, sk);
            if (wr) begin
                n_cmp++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_ffff_ffff;
                if ({ch, dat} !== e) begin
                    n_err++;
                    $display("FAIL alt_word: got chan=%0d data=%h want chan=%0d data=%h", ch, dat, e[32], e[31:0]);
                end
                if (first < 0) first = c;
                last = c;
                nwr++;
            end
        end
        n_cmp++;
        if (nwr !== 8 || (last - first) !== 7) begin
            n_err++;
            $display("FAIL alt_back_to_back: got %0d writes over %0d cycles want 8 over 8", nwr, last - first + 1);
        end
        n_cmp++;
        if (sk !== 16'sd0) begin
            n_err++;
            $display("FAIL alt_skew: got %0d want 0", sk);
        end
    endtask

    task automatic test_burst3();
        logic wr, ch, rd;
        logic [31:0] dat;
        logic signed [15:0] sk;
        logic signed [15:0] peak = -16'sd1;
        logic [32:0] e;
        int nwr = 0;
        for (int i = 0; i < 6; i++) begin
            lq1.push_back(32'h30 + i);
            rq1.push_back(32'h40 + i);
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 32'h30 + 3 * b + i});
            for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 32'h40 + 3 * b + i});
        end
        refresh();
        for (int c = 0; c < 25; c++) begin
            step(1, wr, ch, dat, rd, sk);
            if (sk > peak) peak = sk;
            if (wr) begin
                n_cmp++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_ffff_ffff;
                if ({ch, dat} !== e) begin
                    n_err++;
                    $display("FAIL burst3_word %0d: got chan=%0d data=%h want chan=%0d data=%h", nwr, ch, dat, e[32], e[31:0]);
                end
                nwr++;
            end
        end
        n_cmp++;
        if (nwr !== 12) begin
            n_err++;
            $display("FAIL burst3_count: got %0d want 12", nwr);
        end
        n_cmp++;
        if (peak !== 16'sd3) begin
            n_err++;
            $display("FAIL burst3_skew_peak: got %0d want 3", peak);
        end
        n_cmp++;
        if (sk !== 16'sd0) begin
            n_err++;
            $display("FAIL burst3_skew_end: got %0d want 0", sk);
        end
    endtask

    task automatic test_left_only();
        logic wr, ch, rd;
        logic [31:0] dat;
        logic signed [15:0] sk;
        logic [32:0] e;
        int nwr = 0, nright = 0, first = -1, last = -1;
        for (int i = 0; i < 5; i++) lq0.push_back(32'h50 + i);
`ifdef STRICT_ALTERNATE_EN
        exp_q.push_back({1'b0, 32'h50});
`else
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 32'h50 + i});
`endif
        refresh();
        for (int c = 0; c < 12; c++) begin
            step(0, wr, ch, dat, rd, sk);
            if (wr) begin
                n_cmp++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_ffff_ffff;
                if ({ch, dat} !== e) begin
                    n_err++;
                    $display("FAIL left_only_word: got chan=%0d data=%h want chan=%0d data=%h", ch, dat, e[32], e[31:0]);
                end
                if (ch) nright++;
                if (first < 0) first = c;
                last = c;
                nwr++;
            end
        end
`ifdef STRICT_ALTERNATE_EN
        n_cmp++;
        if (nwr !== 1) begin
            n_err++;
            $display("FAIL strict_stall: got %0d writes want 1", nwr);
        end
        for (int i = 0; i < 4; i++) begin
            rq0.push_back(32'h99 + i);
            exp_q.push_back({1'b1, 32'h99 + i});
            exp_q.push_back({1'b0, 32'h51 + i});
        end
        refresh();
        for (int c = 0; c < 16; c++) begin
            step(0, wr, ch, dat, rd, sk);
            if (wr) begin
                n_cmp++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_ffff_ffff;
                if ({ch, dat} !== e) begin
                    n_err++;
                    $display("FAIL strict_release_word: got chan=%0d data=%h want chan=%0d data=%h", ch, dat, e[32], e[31:0]);
                end
                nwr++;
            end
        end
        n_cmp++;
        if (nwr !== 9) begin
            n_err++;
            $display("FAIL strict_total: got %0d writes want 9", nwr);
        end
        n_cmp++;
        if (sk !== 16'sd1) begin
            n_err++;
            $display("FAIL strict_skew: got %0d want 1", sk);
        end
`else
        n_cmp++;
        if (nwr !== 5 || (last - first) !== 4) begin
            n_err++;
            $display("FAIL left_only_back_to_back: got %0d writes over %0d cycles want 5 over 5", nwr, last - first + 1);
        end
        n_cmp++;
        if (nright !== 0) begin
            n_err++;
            $display("FAIL left_only_right_writes: got %0d want 0", nright);
        end
        n_cmp++;
        if (sk !== 16'sd5) begin
            n_err++;
            $display("FAIL left_only_skew: got %0d want 5", sk);
        end
`endif
    endtask

    task automatic test_full_stall();
        logic wr, ch, rd, full_now;
        logic [31:0] dat;
        logic signed [15:0] sk;
        logic [32:0] e;
        int nwr = 0, stalled = 0;
        for (int i = 0; i < 6; i++) begin
            lq1.push_back(32'h60 + i);
            rq1.push_back(32'h70 + i);
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 32'h60 + 3 * b + i});
            for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 32'h70 + 3 * b + i});
        end
        refresh();
        for (int c = 0; c < 40; c++) begin
            full_now = ofull1;
            step(1, wr, ch, dat, rd, sk);
            if (full_now) begin
                n_cmp++;
                if (wr !== 1'b0 || rd !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_strobes: got wr=%b rd=%b want 0 0", wr, rd);
                end
            end
            if (wr) begin
                n_cmp++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_ffff_ffff;
                if ({ch, dat} !== e) begin
                    n_err++;
                    $display("FAIL full_word %0d: got chan=%0d data=%h want chan=%0d data=%h", nwr, ch, dat, e[32], e[31:0]);
                end
                nwr++;
            end
            if (nwr == 2 && stalled < 4) begin
                ofull1 = 1'b1;
                stalled++;
            end else begin
                ofull1 = 1'b0;
            end
        end
        n_cmp++;
        if (nwr !== 12 || stalled !== 4) begin
            n_err++;
            $display("FAIL full_count: got %0d writes %0d stalls want 12 and 4", nwr, stalled);
        end
    endtask

    task automatic test_reset_midburst();
        logic wr, ch, rd;
        logic [31:0] dat;
        logic signed [15:0] sk;
        logic [32:0] e;
        int nwr = 0;
        for (int i = 0; i < 6; i++) begin
            lq1.push_back(32'h80 + i);
            rq1.push_back(32'h90 + i);
        end
        exp_q.push_back({1'b0, 32'h80});
        exp_q.push_back({1'b0, 32'h81});
        refresh();
        for (int c = 0; c < 10 && nwr < 2; c++) begin
            step(1, wr, ch, dat, rd, sk);
            if (wr) begin
                n_cmp++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_ffff_ffff;
                if ({ch, dat} !== e) begin
                    n_err++;
                    $display("FAIL rst_pre_word: got chan=%0d data=%h want chan=%0d data=%h", ch, dat, e[32], e[31:0]);
                end
                nwr++;
            end
        end
        reset = 1'b1;
        step(1, wr, ch, dat, rd, sk);
        n_cmp++;
        if ({wr, rd, ch} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_cycle_strobes: got wr=%b rd=%b chan=%b want 0 0 0", wr, rd, ch);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 32'h82 + i});
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 32'h90 + i});
        exp_q.push_back({1'b0, 32'h85});
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 32'h93 + i});
        nwr = 0;
        for (int c = 0; c < 25; c++) begin
            step(1, wr, ch, dat, rd, sk);
            if (c == 0) begin
                n_cmp++;
                if (sk !== 16'sd0) begin
                    n_err++;
                    $display("FAIL rst_skew: got %0d want 0", sk);
                end
            end
            if (wr) begin
                n_cmp++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_ffff_ffff;
                if ({ch, dat} !== e) begin
                    n_err++;
                    $display("FAIL rst_post_word %0d: got chan=%0d data=%h want chan=%0d data=%h", nwr, ch, dat, e[32], e[31:0]);
                end
                nwr++;
            end
        end
        n_cmp++;
        if (nwr !== 10) begin
            n_err++;
            $display("FAIL rst_post_count: got %0d want 10", nwr);
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_burst3();
        test_left_only();
        test_full_stall();
        test_reset_midburst();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
